pulse_to_level: RTL
===================

# pulse_to_level

Pulse stretcher: converts single-cycle event strobes (such as those from the level-to-pulse one-shot) back into a clean level of programmable length. The block holds `level` high for a fixed number of cycles per accepted event, then enforces a low guard gap. It sits between event sources (edge detectors, interrupt strobes) and slow consumers (LEDs, handshake lines, other clock-tolerant logic). Events that cannot be honoured are counted, not silently lost.

## Interface
- `HOLD_CYCLES`, 8: cycles `level` stays high per accepted event; range 1..2^CNT_W-1.
- `GAP_CYCLES`, 2: mandatory low cycles after `level` falls; range 0..2^CNT_W-1.
- `CNT_W`, 8: width of the internal hold/gap counter.
- `DROP_W`, 8: width of the `dropped` counter.
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pulse` in 1: event input; every cycle it is sampled high counts as one event.
- `level` out 1: registered stretched level.
- `busy` out 1: high while state is not IDLE.
- `level_fall` out 1: one-cycle strobe, high in the first cycle `level` is low after HOLD.
- `dropped` out DROP_W: saturating count of rejected events.

## Operation
- FSM states are IDLE, HOLD and GAP. All outputs are registered.
- IDLE with `pulse`=1: go to HOLD and load the counter with HOLD_CYCLES-1.
- HOLD: `level`=1 and the counter decrements each cycle.
  - Counter at 0 with no retrigger: go to GAP and load GAP_CYCLES-1. If GAP_CYCLES=0, go to IDLE instead.
  - `level_fall`=1 for that one cycle in both cases.
- GAP: `level`=0 and the counter decrements. Counter at 0: go to IDLE.
- Event in HOLD: handled per Configuration. This includes an event in the final HOLD cycle (counter 0).
- Event in GAP, including the final GAP cycle: rejected and `dropped` increments.
- The IDLE accept and the GAP reject never coincide, because IDLE is only entered the cycle after GAP ends.
- `dropped` saturates at 2^DROP_W-1 and never wraps. It clears only on reset.
- Reset, including mid-HOLD or mid-GAP: state IDLE, counter 0, `level`=0, `busy`=0, `level_fall`=0, `dropped`=0. `pulse` is ignored during any cycle `rst` is high.

## Timing
- Latency: `pulse` sampled at edge k gives `level`=1 from cycle k+1.
- Without retrigger, `level` is high for exactly HOLD_CYCLES cycles.
- `busy` covers HOLD_CYCLES+GAP_CYCLES cycles, starting the same cycle as `level`.
- `level_fall` coincides with the first low cycle of `level` (the first GAP cycle, or the first IDLE cycle when GAP_CYCLES=0).
- Earliest next acceptance: a pulse sampled in the first IDLE cycle, i.e. k+HOLD_CYCLES+GAP_CYCLES+1.
- A `pulse` held high continuously counts as an event every cycle.

## Configuration
- `PULSE_TO_LEVEL_RETRIG_EN` defined:
  - An event in HOLD reloads the counter to HOLD_CYCLES-1, so `level` stays high until HOLD_CYCLES cycles after the last event.
  - The event is not counted as dropped.
  - A continuously high `pulse` keeps `level` high indefinitely.
- Undefined: an event in HOLD is rejected, `dropped` increments and the hold length is unchanged.

## Structure
- Package `pulse_to_level_pkg` holds the state encoding constants (IDLE=2'd0, HOLD=2'd1, GAP=2'd2).
- Sub-module `sat_counter` (parameter W; ports `clk`, `rst`, `inc`, `count`) implements `dropped`.
- The FSM and hold/gap counter live in the top module.

## Test plan
Parameters for all scenarios: HOLD_CYCLES=4, GAP_CYCLES=2, DROP_W=8.
- Single pulse at cycle 10 -> `level` high cycles 11-14, `level_fall` at 15, `busy` 11-16, IDLE at 17, `dropped`=0.
- Pulses at 10 and 12:
  - With RETRIG_EN: `level` high 11-16, `level_fall` at 17, `dropped`=0.
  - Without: `level` high 11-14, `dropped`=1.
- Pulses at 10, 15 and 16 -> `level` unaffected by the later two, `dropped`=2. Pulse at 17 -> accepted, `level` high 18-21.
- DROP_W=2, without RETRIG_EN: pulse at 10, then `pulse` held high cycles 11-16 -> `dropped` saturates at 3 and stays 3.
- Pulse at 10, `rst` high at cycle 12 -> `level`, `busy`=0 from cycle 13, `dropped`=0. Pulse at 14 -> `level` high 15-18.
- GAP_CYCLES=0: pulse at 10 -> `level` high 11-14, `level_fall` at 15, `busy` low at 15. Pulse at 15 -> `level` high 16-19.

Source files
------------

// File: rtl/pulse_to_level_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_to_level_pkg
// Description : Shared state encoding for the pulse_to_level stretcher.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_to_level_pkg;

  // Raw state codes, kept as named constants so other blocks can decode them.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_HOLD = ST_HOLD,
    S_GAP  = ST_GAP
  } state_e;

endpackage : pulse_to_level_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : W-bit up counter that sticks at all-ones instead of wrapping.
//               Clears only on synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step by one unless already pinned at the maximum.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pulse_to_level.sv
`default_nettype none
// ============================================================================
// Module      : pulse_to_level
// Description : Pulse stretcher. Each accepted single-cycle event drives a
//               registered level high for HOLD_CYCLES cycles, followed by a
//               mandatory GAP_CYCLES low guard. Events that cannot be honoured
//               are tallied in a saturating 'dropped' counter.
//               Build option: define PULSE_TO_LEVEL_RETRIG_EN so that an
//               event during HOLD restarts the hold window instead of being
//               counted as dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_to_level
  import pulse_to_level_pkg::*;
#(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 8,
  parameter int DROP_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse,
  output logic              level,
  output logic              busy,
  output logic              level_fall,
  output logic [DROP_W-1:0] dropped
);

`ifdef PULSE_TO_LEVEL_RETRIG_EN
  localparam bit RETRIG_EN = 1'b1;
`else
  localparam bit RETRIG_EN = 1'b0;
`endif

  // Counter load values; the counter runs N-1 down to 0 for an N-cycle phase.
  localparam int HOLD_M1 = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam int GAP_M1  = (GAP_CYCLES  > 0) ? GAP_CYCLES  - 1 : 0;
  localparam logic [CNT_W-1:0] HOLD_LOAD = HOLD_M1[CNT_W-1:0];
  localparam logic [CNT_W-1:0] GAP_LOAD  = GAP_M1[CNT_W-1:0];
  localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             level_q,      level_d;
  logic             busy_q,       busy_d;
  logic             level_fall_q, level_fall_d;
  logic             drop_inc;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drop_inc = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pulse) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end

      S_HOLD: begin
        if (pulse && RETRIG_EN) begin
          // Restart the window; level stays high HOLD_CYCLES past this event.
          cnt_d = HOLD_LOAD;
        end else begin
          // Without retrigger any event here, even on the last cycle, is lost.
          drop_inc = pulse;
          if (cnt_q == '0) begin
            if (HAS_GAP) begin
              state_d = S_GAP;
              cnt_d   = GAP_LOAD;
            end else begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      S_GAP: begin
        // Guard gap: nothing is accepted until IDLE is reached.
        drop_inc = pulse;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they appear registered,
    // aligned with the state they describe.
    level_d      = (state_d == S_HOLD);
    busy_d       = (state_d != S_IDLE);
    level_fall_d = (state_q == S_HOLD) && (state_d != S_HOLD);
  end

  // State, counter and output registers; reset has priority over pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      busy_q       <= 1'b0;
      level_fall_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      busy_q       <= busy_d;
      level_fall_q <= level_fall_d;
    end
  end

  // Rejected-event tally; pulses seen while in reset never reach it.
  sat_counter #(
    .W (DROP_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_inc & ~rst),
    .count (dropped)
  );

  assign level      = level_q;
  assign busy       = busy_q;
  assign level_fall = level_fall_q;

endmodule : pulse_to_level
`default_nettype wire
